// File: rtl/signed_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Holds the controller state encoding and the step-counter width rule.
package signed_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Counter must hold W-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/twos_complementer.sv
// Conditional two's-complement negation: y = neg ? -a : a.
// Used both for operand magnitude extraction and result sign correction.
module twos_complementer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/signed_divider.sv
// Sequential radix-2 restoring signed divider, one quotient bit per clock.
// Truncates toward zero; flags divide-by-zero and the MIN / -1 overflow.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int INPUT_LENGTH = 16
) (
  input  logic                           iClk,
  input  logic                           iRstN,
  input  logic                           iStart,
  input  logic signed [INPUT_LENGTH-1:0] iA,
  input  logic signed [INPUT_LENGTH-1:0] iB,
  output logic                           oBusy,
  output logic                           oDone,
  output logic signed [INPUT_LENGTH-1:0] oQuot,
  output logic signed [INPUT_LENGTH-1:0] oRem,
  output logic                           oDivByZero,
  output logic                           oOverflow
);

  localparam int             W        = INPUT_LENGTH;
  localparam int             CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W - 1);
  localparam logic [W-1:0]   MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  div_state_e state_q, state_d;

  logic             a_neg_q, b_neg_q, dz_q, ovf_q;
  logic [W-1:0]     a_raw_q;
  logic [W-1:0]     dvsr_q;
  logic [W-1:0]     quo_q;
  logic [W:0]       rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic             done_q, dz_out_q, ovf_out_q;
  logic [W-1:0]     quot_out_q, rem_out_q;

  logic [W-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic [W+1:0]     shift_rem, trial;
  logic             trial_ok;

  twos_complementer #(.WIDTH(W)) u_mag_a (.a(iA),  .neg(iA[W-1]), .y(a_mag));
  twos_complementer #(.WIDTH(W)) u_mag_b (.a(iB),  .neg(iB[W-1]), .y(b_mag));
  twos_complementer #(.WIDTH(W)) u_fix_q (.a(quo_q), .neg(a_neg_q ^ b_neg_q), .y(quo_fix));
  twos_complementer #(.WIDTH(W)) u_fix_r (.a(rem_q[W-1:0]), .neg(a_neg_q), .y(rem_fix));

  // Restoring step: bring in the next dividend bit, trial-subtract the divisor.
  // The partial remainder stays below the divisor magnitude, so the extra top
  // bit of the difference is a reliable borrow indicator.
  assign shift_rem = {rem_q, quo_q[W-1]};
  assign trial     = shift_rem - {2'b00, dvsr_q};
  assign trial_ok  = ~trial[W+1];

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = ITER;
      ITER:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      a_raw_q    <= '0;
      dvsr_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dz_out_q   <= 1'b0;
      ovf_out_q  <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            a_neg_q <= iA[W-1];
            b_neg_q <= iB[W-1];
            dz_q    <= (iB == '0);
            ovf_q   <= (iA == MIN_VAL) && (iB == '1);
            a_raw_q <= iA;
            dvsr_q  <= b_mag;
            quo_q   <= a_mag;
            rem_q   <= '0;
            cnt_q   <= CNT_INIT;
          end
        end
        ITER: begin
          quo_q <= {quo_q[W-2:0], trial_ok};
          rem_q <= trial_ok ? trial[W:0] : shift_rem[W:0];
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          // Exceptional results override the (well-defined but meaningless) datapath.
          if (dz_q) begin
            quot_out_q <= '1;
            rem_out_q  <= a_raw_q;
          end else if (ovf_q) begin
            quot_out_q <= MIN_VAL;
            rem_out_q  <= '0;
          end else begin
            quot_out_q <= quo_fix;
            rem_out_q  <= rem_fix;
          end
          dz_out_q  <= dz_q;
          ovf_out_q <= ovf_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oBusy      = (state_q != IDLE);
  assign oDone      = done_q;
  assign oQuot      = quot_out_q;
  assign oRem       = rem_out_q;
  assign oDivByZero = dz_out_q;
  assign oOverflow  = ovf_out_q;

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential radix-2 signed integer divider, the inverse operation to the team's combinational Booth multiplier in the arithmetic library. It accepts a two's-complement dividend and divisor on a start strobe, runs one restoring-division step per clock on operand magnitudes, applies sign correction, and presents quotient and remainder with a one-cycle done pulse. It is intended for datapaths where a multi-cycle divide is acceptable in exchange for small area.

## Interface
- INPUT_LENGTH, 16: width W of dividend, divisor, quotient and remainder; even, ≥ 4.
- iClk  in  1  rising-edge clock.
- iRstN  in  1  asynchronous, active-low reset.
- iStart  in  1  start request; sampled only in IDLE.
- iA  in  W  signed dividend, captured on an accepted iStart.
- iB  in  W  signed divisor, captured on an accepted iStart.
- oBusy  out  1  high while a division is in flight (ITER, FIX).
- oDone  out  1  one-cycle pulse: results valid and updated.
- oQuot  out  W  signed quotient; holds until the next oDone.
- oRem  out  W  signed remainder; holds until the next oDone.
- oDivByZero  out  1  set with oDone when the divisor was 0; holds with the results.
- oOverflow  out  1  set with oDone for (−2^(W−1)) / (−1); holds with the results.

## Operation
- Semantics: truncation toward zero, so the remainder takes the dividend's sign and |oRem| < |iB|. iA = oQuot·iB + oRem for all non-exceptional cases.
- States: IDLE, ITER, FIX.
- IDLE: on iStart, register sign(iA), sign(iB), |iA| and |iB| as W-bit unsigned values (|−2^(W−1)| = 2^(W−1) fits), clear the W+1-bit partial remainder, set the step counter to W−1, and go to ITER.
- ITER: each cycle, shift {rem, dividend} left by 1 and trial-subtract the divisor magnitude from the upper W+1 bits. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. Decrement the counter. After the step at counter 0, go to FIX.
- FIX: negate the quotient if the signs differ, and negate the remainder if the dividend was negative.
  - Divide by zero: oQuot = all ones, oRem = iA, oDivByZero = 1.
  - Overflow case: oQuot = −2^(W−1) (wrapped), oRem = 0, oOverflow = 1.
  - Register all outputs, pulse oDone, and return to IDLE.
- iStart outside IDLE is ignored. Operands are not sampled after acceptance, so input changes during ITER have no effect.
- Exceptional cases take the full latency. Timing is data-independent.

## Timing
- iStart is accepted at edge 0. ITER occupies edges 1..W. FIX registers results at edge W+1. oDone is high in the cycle after edge W+1, so latency is W+1 cycles (17 for W = 16).
- oBusy rises after edge 0 and falls in the same cycle oDone rises.
- Back-to-back: iStart asserted while oDone is high is accepted, because the state is already IDLE. Sustained throughput is one result per W+1 cycles.
- Reset values: state IDLE; oBusy, oDone, oDivByZero, oOverflow = 0; oQuot, oRem = 0; all internal registers = 0.
- Reset asserted mid-operation aborts immediately. oDone does not pulse for the aborted operation, and the outputs return to their reset values.

## Structure
- Shared arithmetic package holds the state enum (IDLE/ITER/FIX) and a clog2-based counter-width constant. The restoring step is written inline.
- The existing twos_complementer sub-module is instantiated for operand magnitude extraction and for quotient/remainder sign correction, with WIDTH = INPUT_LENGTH.

## Test plan
- W = 16. iA = 100, iB = 7, iStart for 1 cycle -> oDone exactly 17 cycles later; oQuot = 14, oRem = 2; flags 0.
- −100/7 -> −14, −2. 100/−7 -> −14, 2. −100/−7 -> 14, −2.
- iA = 0x8000, iB = 0xFFFF -> oQuot = 0x8000, oRem = 0, oOverflow = 1. iA = 0x8000, iB = 1 -> 0x8000, 0, oOverflow = 0.
- iA = 5, iB = 0 -> oQuot = 0xFFFF, oRem = 5, oDivByZero = 1, same 17-cycle latency.
- Back-to-back and busy rejection: new iStart with 1000/33 in the oDone cycle -> accepted; next oDone 17 cycles later with 30, 10. iStart pulses during ITER -> ignored, no extra oDone.
- Random-reset sweep (10k random operand pairs versus a reference model): iRstN pulsed low at cycle 8 of a division -> outputs 0 and oBusy 0 immediately, no oDone; the next request completes correctly.
